// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer and the opcode decoder.
// Keeping the opcode table in one place stops the decoder and the sequencer from disagreeing.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: shares one memory port between fetch and load/store, issues register write strobes.
// Latency: 4 cycles per ALU instruction, 5 per load/store, plus one cycle per mem_ready=0 wait.
// Backpressure: mem_ready=0 holds FETCH/MEM with mem_req asserted; run is sampled only in IDLE and WB.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             dec_reg_wen,
  input  logic             dec_mem_rw,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  output logic [2:0]       state
);

  state_t state_q, state_d;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WB) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_we       = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    retire       = 1'b0;
    trap         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = op_legal(opcode) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        alu_we  = 1'b1;
        state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_rw;
        if (mem_ready) begin
          mdr_we  = ~dec_mem_rw;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        // Stores and branches arrive with dec_reg_wen low, so no special case here.
        rf_we   = dec_reg_wen;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scripted per-instruction trace model for mc_sequencer; a second instance with a 3-bit counter exercises wrap.
module tb_mc_sequencer;
  import mc_sequencer_pkg::*;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  logic clk = 1'b0;
  logic rst_n, run, dec_reg_wen, dec_mem_rw, mem_ready;
  logic [6:0] opcode;
  logic mem_req, mem_we, mem_addr_sel, ir_we, alu_we, mdr_we, rf_we, pc_we, retire, trap;
  logic [31:0] retire_cnt;
  logic [2:0] state;
  logic b_req, b_we, b_sel, b_ir, b_alu, b_mdr, b_rf, b_pc, b_ret, b_trap;
  logic [2:0] b_cnt, b_state;

  int n_tests = 0, n_fail = 0;
  int unsigned model_cnt = 0;
  int n_memsel = 0, n_mdr = 0;
  logic exp_vld = 1'b0;
  logic [2:0] exp_st;
  logic [9:0] exp_sb;
  logic at_idle = 1'b1;
  logic mid_run_rand = 1'b1;
  logic [6:0] legal_ops [9];

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .dec_reg_wen(dec_reg_wen),
    .dec_mem_rw(dec_mem_rw), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .alu_we(alu_we), .mdr_we(mdr_we),
    .rf_we(rf_we), .pc_we(pc_we), .retire(retire), .retire_cnt(retire_cnt),
    .trap(trap), .state(state)
  );

  mc_sequencer #(.CNT_W(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .dec_reg_wen(dec_reg_wen),
    .dec_mem_rw(dec_mem_rw), .mem_ready(mem_ready), .mem_req(b_req), .mem_we(b_we),
    .mem_addr_sel(b_sel), .ir_we(b_ir), .alu_we(b_alu), .mdr_we(b_mdr),
    .rf_we(b_rf), .pc_we(b_pc), .retire(b_ret), .retire_cnt(b_cnt),
    .trap(b_trap), .state(b_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {mem_req, mem_we, mem_addr_sel, ir_we, alu_we, mdr_we, rf_we, pc_we, retire, trap}
  function automatic logic [9:0] sb(input logic req, we, sel, ir, alu, mdr, rf, pc, ret, trp);
    return {req, we, sel, ir, alu, mdr, rf, pc, ret, trp};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rnd_run();
    return mid_run_rand ? rb() : 1'b0;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("strobes", 32'({mem_req, mem_we, mem_addr_sel, ir_we, alu_we, mdr_we, rf_we, pc_we, retire, trap}), 32'(exp_sb));
      chk("state", 32'(state), 32'(exp_st));
      chk("retire_cnt", retire_cnt, model_cnt);
      chk("strobes_w3", 32'({b_req, b_we, b_sel, b_ir, b_alu, b_mdr, b_rf, b_pc, b_ret, b_trap}), 32'(exp_sb));
      chk("retire_cnt_w3", 32'(b_cnt), model_cnt % 8);
      if (mem_req && mem_addr_sel) n_memsel++;
      if (mdr_we) n_mdr++;
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cyc(input logic [2:0] st, input logic mr, input logic rn, input logic [9:0] s);
    mem_ready = mr;
    run       = rn;
    exp_st    = st;
    exp_sb    = s;
    exp_vld   = 1'b1;
    @(posedge clk);
    #1;
    if (s[1]) model_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(S_IDLE, rb(), 1'b0, '0);
    cyc(S_IDLE, rb(), 1'b1, '0);
    at_idle = 1'b0;
  endtask

  task automatic instr(input logic [6:0] op, input int fw, input int mw,
                       input logic wen, input logic rw, input logic run_end);
    logic is_ls;
    is_ls = (op == OP_LOAD) || (op == OP_STORE);
    dec_reg_wen = wen;
    dec_mem_rw  = rw;
    opcode      = 7'($urandom);
    for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, rnd_run(), sb(1,0,0,0,0,0,0,0,0,0));
    cyc(S_FETCH, 1'b1, rnd_run(), sb(1,0,0,1,0,0,0,0,0,0));
    opcode = op;
    cyc(S_DECODE, rb(), rnd_run(), '0);
    if (!is_legal(op)) begin
      for (int i = 0; i < 20; i++) cyc(S_TRAP, rb(), rb(), sb(0,0,0,0,0,0,0,0,0,1));
      return;
    end
    cyc(S_EXEC, rb(), rnd_run(), sb(0,0,0,0,1,0,0,0,0,0));
    if (is_ls) begin
      for (int i = 0; i < mw; i++) cyc(S_MEM, 1'b0, rnd_run(), sb(1,rw,1,0,0,0,0,0,0,0));
      cyc(S_MEM, 1'b1, rnd_run(), sb(1,rw,1,0,0,!rw,0,0,0,0));
    end
    cyc(S_WB, rb(), run_end, sb(0,0,0,0,0,0,wen,1,1,0));
    at_idle = !run_end;
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without waiting for a clock edge.
  task automatic async_reset(input string tag);
    exp_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_outs"}, 32'({mem_req, mem_we, mem_addr_sel, ir_we, alu_we, mdr_we, rf_we, pc_we, retire, trap}), 32'd0);
    chk({tag, "_cnt"}, retire_cnt, 32'd0);
    model_cnt = 0;
    at_idle   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0; dec_reg_wen = 1'b0; dec_mem_rw = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_outs", 32'({mem_req, ir_we, pc_we, retire, trap}), 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(1);
    instr(OP_IMM, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("addi_cnt", retire_cnt, 32'd1);

    n_memsel = 0; n_mdr = 0;
    instr(OP_LOAD, 0, 3, 1'b1, 1'b0, 1'b1);
    chk("lw_req_hold", 32'(n_memsel), 32'd4);
    chk("lw_mdr_pulses", 32'(n_mdr), 32'd1);
    chk("lw_cnt", retire_cnt, 32'd2);

    instr(OP_STORE, 1, 0, 1'b0, 1'b1, 1'b1);
    chk("sw_cnt", retire_cnt, 32'd3);

    mid_run_rand = 1'b0;
    instr(OP_OP, 0, 0, 1'b1, 1'b0, 1'b0);
    idle(4);
    mid_run_rand = 1'b1;

    for (int k = 0; k < 80; k++) begin
      logic ld, st;
      if (at_idle) idle($urandom_range(0, 2));
      op = legal_ops[$urandom_range(0, 8)];
      ld = (op == OP_LOAD);
      st = (op == OP_STORE);
      instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
            (op == OP_BRANCH || st) ? 1'b0 : rb(),
            st ? 1'b1 : (ld ? 1'b0 : rb()),
            $urandom_range(0, 3) != 0);
    end

    if (at_idle) idle(0);
    instr(7'b1111111, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("trap_sticky", 32'(trap), 32'd1);
    async_reset("trap_rst");
    chk("trap_cleared", 32'(trap), 32'd0);

    idle(0);
    opcode = OP_IMM;
    mem_ready = 1'b0;
    run = 1'b1;
    chk("fetch_wait_req", 32'(mem_req), 32'd1);
    async_reset("fetch_rst");

    idle(0);
    instr(OP_JAL, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_cnt", retire_cnt, 32'd1);
    exp_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
